// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - iterative unsigned restoring divider with IDLE/RUN/DONE sequencer
//
// Purpose:
//   Accepts dividend/divisor with a start pulse and produces one quotient bit
//   per clock over W RUN cycles. A one-cycle done strobe then presents the
//   quotient, the remainder and a divide-by-zero flag. A zero divisor skips RUN
//   and goes straight to DONE with quotient = all ones and remainder = dividend.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   CLR_bar      asynchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high while in RUN
//   done         one-cycle strobe, high while in DONE
//   quotient     registered result, held between operations
//   remainder    registered result, held between operations
//   div_by_zero  registered flag, valid with done, held until the next accepted start

module divider_sequencer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         CLR_bar,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  qacc_q, qacc_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  remr_q, remr_d;
  logic          dbz_q, dbz_d;

  // One restoring step. The partial remainder never reaches the divisor after
  // a step, so its MSB is always zero going in; the compare is still done on
  // W+1 bits because the shifted-in value can exceed W bits.
  logic [W:0]   step_t;
  logic         step_ge;
  logic [W:0]   step_rem;
  logic [W-1:0] step_q;

  assign step_t   = {rem_q[W-1:0], qacc_q[W-1]};
  assign step_ge  = (step_t >= {1'b0, dvs_q});
  assign step_rem = step_ge ? (step_t - {1'b0, dvs_q}) : step_t;
  assign step_q   = {qacc_q[W-2:0], step_ge};

  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[W];

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      qacc_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remr_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remr_d  = remr_q;
    dbz_d   = dbz_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE so operations can run
      // back-to-back without an idle gap.
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            remr_d  = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            qacc_d  = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
            cnt_d   = CW'(W);
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d  = step_rem;
        qacc_d = step_q;
        cnt_d  = cnt_q - CW'(1);
        // Results are published only on the final step so the outputs of the
        // previous operation stay stable throughout RUN.
        if (cnt_q == CW'(1)) begin
          quot_d  = step_q;
          remr_d  = step_rem[W-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remr_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - scoreboard bench for divider_sequencer

module tb_divider_sequencer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         CLR_bar = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  divider_sequencer #(.W(W)) dut (
    .CLK         (CLK),
    .CLR_bar     (CLR_bar),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  res_t exp_q[$];
  res_t last_res = '0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    if (b == 0) begin
      r.q = {W{1'b1}};
      r.r = a;
      r.z = 1'b1;
    end else begin
      r.q = a / b;
      r.r = a % b;
      r.z = 1'b0;
    end
    return r;
  endfunction

  // Drive a request at the current falling edge and record its expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(model(a, b));
  endtask

  // Follows the request issued just before; optionally pulses a stray start
  // during RUN at sample index inj. Returns at the falling edge where done=1.
  task automatic wait_done(input bit is_dbz, input int inj);
    int lat;
    int bcnt;
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge CLK);
      if (i == 0) start = 1'b0;
      if (i == inj) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
      end
      if (i == inj + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("done_latency", 32'(lat), is_dbz ? 32'd0 : 32'(W));
    chk("busy_cycles", 32'(bcnt), is_dbz ? 32'd0 : 32'(W));
  endtask

  // Monitor: pops the scoreboard on every done strobe; between strobes the
  // outputs must equal the last completed result (zero after reset).
  always @(negedge CLK) begin
    res_t e;
    if (!CLR_bar) begin
      last_res = '0;
    end else if (done) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        last_res = e;
      end
    end else begin
      chk("hold_quotient", 32'(quotient), 32'(last_res.q));
      chk("hold_remainder", 32'(remainder), 32'(last_res.r));
      if (!busy) chk("hold_div_by_zero", 32'(div_by_zero), 32'(last_res.z));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge CLK);
    CLR_bar = 1'b1;

    @(negedge CLK); issue(8'd100, 8'd7); wait_done(1'b0, -1);
    @(negedge CLK); issue(8'd255, 8'd1); wait_done(1'b0, -1);
    repeat (2) @(negedge CLK);
    issue(8'd5, 8'd9); wait_done(1'b0, -1);
    @(negedge CLK); issue(8'd37, 8'd0); wait_done(1'b1, -1);
    @(negedge CLK); issue(8'd20, 8'd4); wait_done(1'b0, -1);
    @(negedge CLK); issue(8'd200, 8'd9); wait_done(1'b0, 3);
    @(negedge CLK); issue(8'd17, 8'd5); wait_done(1'b0, -1);
    issue(8'd81, 8'd9); wait_done(1'b0, -1);
    // Zero divisor back-to-back from DONE, then a normal op back-to-back.
    issue(8'd9, 8'd0); wait_done(1'b1, -1);
    issue(8'd250, 8'd250); wait_done(1'b0, -1);

    // Reset in the middle of RUN: outputs clear at once, no done follows.
    @(negedge CLK); issue(8'd100, 8'd7);
    @(negedge CLK); start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 CLR_bar = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_quotient", 32'(quotient), 32'd0);
    chk("midrun_reset_remainder", 32'(remainder), 32'd0);
    chk("midrun_reset_div_by_zero", 32'(div_by_zero), 32'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge CLK);
    CLR_bar = 1'b1;
    repeat (2 * W) @(negedge CLK);
    issue(8'd100, 8'd7); wait_done(1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
      issue(a, b);
      wait_done(b == '0, -1);
    end

    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
